// File: rtl/pb_uart_tx.sv
// Picoblaze port-mapped UART transmitter: a byte FIFO feeding an 8N1 serialiser,
// plus a STATUS/CTRL/COUNT register window and a level interrupt on TX drain.
module pb_uart_tx #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic [7:0] in_port,
    output logic       interrupt,
    output logic       uart_tx
);

    localparam int unsigned        Depth     = 1 << FIFO_AW;
    localparam logic [7:0]         AddrData  = BASE_ADDR;
    localparam logic [7:0]         AddrCtrl  = BASE_ADDR + 8'd1;
    localparam logic [7:0]         AddrCount = BASE_ADDR + 8'd2;
    localparam logic [15:0]        DivLast   = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CntOne    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CntFull   = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic [7:0]         mem [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [7:0]         fifo_rdata;
    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop;

    logic               tx_en_q, irq_en_q;
    logic               overflow_q, irq_pending_q, interrupt_q;
    logic [7:0]         in_port_q, rd_data;
    logic               ctrl_wr, status_rd, frame_done, tx_ready;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntFull);
    assign fifo_rdata = mem[rd_ptr_q];

    assign push_req  = write_strobe && (port_id == AddrData);
    assign ctrl_wr   = write_strobe && (port_id == AddrCtrl);
    assign status_rd = read_strobe && (port_id == AddrData);
    // A full FIFO still accepts a byte when the serialiser frees a slot this cycle.
    assign push      = push_req && (!fifo_full || pop);
    assign tx_ready  = tx_en_q && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_ready) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = DivLast;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    cnt_d   = DivLast;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    cnt_d = DivLast;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    frame_done = 1'b1;
                    // Chain straight into the next start bit so frames abut.
                    if (tx_ready) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        cnt_d   = DivLast;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (port_id == AddrData) begin
            rd_data = {3'b000, irq_pending_q, overflow_q, state_q != StIdle, fifo_full, fifo_empty};
        end else if (port_id == AddrCtrl) begin
            rd_data = {6'b000000, irq_en_q, tx_en_q};
        end else if (port_id == AddrCount) begin
            rd_data = 8'(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_en_q       <= 1'b0;
            irq_en_q      <= 1'b0;
            overflow_q    <= 1'b0;
            irq_pending_q <= 1'b0;
            interrupt_q   <= 1'b0;
            in_port_q     <= '0;
        end else begin
            if (ctrl_wr) begin
                tx_en_q  <= out_port[0];
                irq_en_q <= out_port[1];
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end else if (status_rd) begin
                overflow_q <= 1'b0;
            end
            if (frame_done && fifo_empty) begin
                irq_pending_q <= 1'b1;
            end else if (interrupt_ack || (ctrl_wr && out_port[7])) begin
                irq_pending_q <= 1'b0;
            end
            interrupt_q <= irq_pending_q & irq_en_q;
            in_port_q   <= rd_data;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = interrupt_q;
    assign uart_tx   = tx_q;

endmodule

// File: tb/tb_pb_uart_tx.sv
// Bench for pb_uart_tx: directed register/FIFO stimulus, with a serial-frame monitor
// and a register-read monitor popping expected values from scoreboard queues.
module tb_pb_uart_tx;

    localparam logic [7:0] AddrData  = 8'h10;
    localparam logic [7:0] AddrCtrl  = 8'h11;
    localparam logic [7:0] AddrCount = 8'h12;
    localparam int         Div       = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] port_id, out_port, in_port;
    logic       write_strobe, read_strobe, interrupt_ack;
    logic       interrupt, uart_tx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] exp_frames[$];
    logic [7:0] exp_rd_v[$];
    string      exp_rd_n[$];
    int         start_times[$];
    int         irq_rises[$];

    pb_uart_tx #(
        .BASE_ADDR(8'h10),
        .CLK_DIV  (Div),
        .FIFO_AW  (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .interrupt_ack(interrupt_ack),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .uart_tx      (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Register-read monitor: in_port holds the addressed register while read_strobe is high.
    always @(posedge clk) begin : rd_mon
        string      nm;
        logic [7:0] v;
        #1;
        if (read_strobe === 1'b1) begin
            if (exp_rd_v.size() == 0) begin
                check("unexpected_read", 32'(in_port), 32'hFFFF_FFFF);
            end else begin
                nm = exp_rd_n.pop_front();
                v  = exp_rd_v.pop_front();
                check(nm, 32'(in_port), 32'(v));
            end
        end
    end

    // Serial monitor: captures a full 10-bit frame, every bit held for Div cycles.
    initial begin : frame_mon
        logic [9:0] bits;
        logic       ok, aborted;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && uart_tx === 1'b0) begin
                start_times.push_back(cyc);
                ok      = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < Div; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (reset_n !== 1'b1) aborted = 1'b1;
                        if (s == 0) bits[b] = uart_tx;
                        else if (uart_tx !== bits[b]) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (exp_frames.size() == 0) begin
                        check("unexpected_frame", 32'({ok, bits}), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_frames.pop_front();
                        check("frame", 32'({ok, bits}), 32'({1'b1, 1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    initial begin : irq_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (interrupt === 1'b1 && !prev) irq_rises.push_back(cyc);
            prev = (interrupt === 1'b1);
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d, output int e);
        @(negedge clk);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        e            = cyc + 1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        port_id = a;
        exp_rd_v.push_back(exp);
        exp_rd_n.push_back(nm);
        @(negedge clk);
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int e, e1, e2, e3, ns, ni, c;
        reset_n       = 1'b0;
        port_id       = 8'h00;
        out_port      = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;

        // Reset state
        do_reset(3);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_in_port", 32'(in_port), 32'd0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        rd(AddrData, 8'h01, "rst_status");
        rd(AddrCount, 8'h00, "rst_count");
        rd(AddrCtrl, 8'h00, "rst_ctrl");

        // Single byte A5, interrupt 42 cycles after the push edge
        wr(AddrCtrl, 8'h03, e);
        rd(AddrCtrl, 8'h03, "ctrl_readback");
        ns = start_times.size();
        ni = irq_rises.size();
        exp_frames.push_back(8'hA5);
        wr(AddrData, 8'hA5, e);
        repeat (46) @(negedge clk);
        check("single_start", 32'(start_times.size() > ns ? start_times[ns] : -1), 32'(e + 1));
        check("single_irq_time", 32'(irq_rises.size() > ni ? irq_rises[ni] : -1), 32'(e + 42));
        @(negedge clk);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        check("irq_hold_at_ack", 32'(interrupt), 32'd1);
        @(negedge clk);
        check("irq_clear_after_ack", 32'(interrupt), 32'd0);
        rd(AddrData, 8'h01, "status_after_ack");

        // Overflow with transmitter disabled
        wr(AddrCtrl, 8'h00, e);
        for (int i = 0; i < 17; i++) wr(AddrData, 8'(i + 8'h30), e);
        rd(AddrCount, 8'h10, "ovf_count");
        rd(AddrData, 8'h0A, "ovf_status1");
        rd(AddrData, 8'h02, "ovf_status2");
        do_reset(3);
        rd(AddrCount, 8'h00, "count_after_reset");

        // Back-to-back frames, one interrupt after the last
        wr(AddrCtrl, 8'h03, e);
        ns = start_times.size();
        ni = irq_rises.size();
        exp_frames.push_back(8'h01);
        exp_frames.push_back(8'h02);
        exp_frames.push_back(8'h03);
        wr(AddrData, 8'h01, e1);
        wr(AddrData, 8'h02, e2);
        wr(AddrData, 8'h03, e3);
        repeat (130) @(negedge clk);
        check("b2b_frames", 32'(start_times.size() - ns), 32'd3);
        if (start_times.size() >= ns + 3) begin
            check("b2b_start1", 32'(start_times[ns]), 32'(e1 + 1));
            check("b2b_start2", 32'(start_times[ns + 1]), 32'(e1 + 1 + 10 * Div));
            check("b2b_start3", 32'(start_times[ns + 2]), 32'(e1 + 1 + 20 * Div));
        end
        check("b2b_irq_count", 32'(irq_rises.size() - ni), 32'd1);
        check("b2b_irq_time", 32'(irq_rises.size() > ni ? irq_rises[ni] : -1),
              32'(e1 + 2 + 30 * Div));

        // Decode, CTRL bit7 clear, ignored writes
        wr(AddrCtrl, 8'h80, e);
        @(negedge clk);
        check("irq_clear_by_ctrl", 32'(interrupt), 32'd0);
        rd(AddrCtrl, 8'h00, "ctrl_after_80");
        rd(AddrData, 8'h01, "status_after_80");
        rd(8'h20, 8'h00, "unmapped_read");
        wr(AddrData, 8'h77, e);
        wr(8'h20, 8'h55, e);
        rd(AddrCount, 8'h01, "count_after_unmapped_wr");
        wr(AddrData, 8'h66, e);
        rd(AddrCount, 8'h02, "count_two");
        rd(AddrData, 8'h00, "status_two");

        // Reset during DATA bit 3 of 0x77 (bit3 = 0)
        ns = start_times.size();
        wr(AddrCtrl, 8'h01, c);
        while (cyc < c + 17) @(negedge clk);
        check("bit3_level", 32'(uart_tx), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midframe_rst_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("no_frame_after_rst", 32'(start_times.size() - ns), 32'd1);
        check("idle_after_rst", 32'(uart_tx), 32'd1);
        rd(AddrCount, 8'h00, "count_after_midframe_rst");

        repeat (4) @(negedge clk);
        check("frames_outstanding", 32'(exp_frames.size()), 32'd0);
        check("reads_outstanding", 32'(exp_rd_v.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
